tok_loader: RTL and testbench
=============================

Name: tok_loader

Overview:
- UART boot loader directly upstream of the TOK core.
- Receives a framed program image from the UART receiver and writes it byte-by-byte into the core's 8-bit program RAM write port.
- Holds the core in reset until a frame passes its checksum, then releases it.
- While the core runs, a UART line break returns it to loading.

Parameters:
ADDR_W, 8, program RAM address width; maximum image length is 2**ADDR_W bytes
TIMEOUT, 1000000, idle clk cycles allowed between bytes inside a frame before abort
SYNC_CHAR, 8'h3A, frame start byte (":")

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_valid  input  1  UART receive byte available
rx_data  input  8  UART receive byte
rx_error  input  1  UART framing error / line break, single-cycle pulse
rx_rd  output  1  consume current UART byte (combinational)
ram_we  output  1  program RAM write strobe (registered)
ram_waddr  output  ADDR_W  program RAM write address (registered)
ram_din  output  8  program RAM write data (registered)
core_run  output  1  1 = core out of reset (drives core reset, active-low side)
busy  output  1  1 = frame in progress (state LEN, DATA or SUM)
load_err  output  1  sticky error flag
tx_wr  output  1  acknowledge byte write strobe (feature only)
tx_data  output  8  acknowledge byte
tx_busy  input  1  UART transmitter busy

Behaviour:
- Reset (async, active-high) sets:
  - state=SYNC
  - core_run=0, load_err=0, ram_we=0, ram_waddr=0, ram_din=0
  - tx_wr=0, tx_data=0
  - byte counter=0, checksum=0, timeout counter=0
- Frame format: SYNC_CHAR, LEN, LEN' data bytes, SUM.
  - LEN'=LEN, except LEN=0 means 256.
  - Frame is valid when (LEN + all data + SUM) mod 256 == 0.
- rx_rd = rx_valid & (state in SYNC, LEN, DATA, SUM). The byte is accepted in that cycle.
  - rx_rd is 0 in RUN, so the core owns the UART.
- States:
  - SYNC: accepted byte == SYNC_CHAR -> LEN and clear load_err; any other byte is dropped.
  - LEN: store LEN'. If LEN' > 2**ADDR_W -> ERR. Otherwise checksum=LEN, count=0 -> DATA.
  - DATA: each accepted byte produces ram_we=1, ram_waddr=count, ram_din=byte in the next cycle (latency 1). checksum += byte; count++. Move to SUM when count reaches LEN'-1 on accept.
  - SUM: if (checksum+byte)[7:0]==0 -> RUN, else -> ERR.
  - RUN: core_run=1, registered in the cycle after SUM accept. An rx_error pulse -> SYNC with core_run=0 in the next cycle. rx_valid is ignored.
  - ERR: load_err=1 for one transition cycle, then -> SYNC. load_err stays 1 until the next SYNC_CHAR is accepted.
- Timeout:
  - In LEN, DATA and SUM, the counter increments each cycle without an accept and clears on accept.
  - At count == TIMEOUT-1 -> ERR.
  - Partial RAM contents are left as written; the core stays in reset.
- rx_error in SYNC/LEN/DATA/SUM: -> ERR. Any pending accept in that cycle is discarded.
- Simultaneous timeout expiry and byte accept: the accept wins and the counter clears.
- ram_we is asserted for exactly one cycle per data byte. No write occurs for SYNC, LEN or SUM bytes.
- Byte counter is ADDR_W+1 bits wide. Addresses never wrap inside a frame, because oversize LEN is rejected.
- busy = state in {LEN, DATA, SUM}.
- Mid-frame reset: all state returns to reset values immediately. No further RAM writes occur.

Optional Feature:
TOK_LOADER_ACK_EN
- Defined:
  - On entering RUN, queue ack "K" (8'h4B); on entering ERR, queue "!" (8'h21).
  - tx_wr is pulsed for one cycle, with tx_data held, on the first cycle with tx_busy=0.
  - At most one ack is pending; a newer ack overwrites an unsent one.
  - In RUN, core_run rises regardless of ack status. The external UART mux gives the loader priority while its ack is pending.
- Not defined: tx_wr constant 0, tx_data constant 0, tx_busy ignored.

Test Plan:
- Good load: bytes 3A 03 11 22 33 97 -> writes (0,11)(1,22)(2,33), one cycle after each accept; core_run=1 one cycle after the 97 accept; load_err=0.
- Bad checksum: 3A 02 AA BB 00 -> two writes, then load_err=1, core_run=0, state SYNC; a following good frame clears load_err and sets core_run=1.
- Garbage before sync, then LEN=0: bytes 55 00 3A 00, 256 bytes of value i, SUM=0x80 -> 256 writes at addr 0..255, no write for 55, core_run=1.
- Timeout: TIMEOUT=100; 3A 04 01, then idle 100 cycles -> ERR, load_err=1, exactly one RAM write, rx_rd=0 never stuck.
- Break while running: after a good load, pulse rx_error -> core_run=0 next cycle, busy=0, rx_rd follows rx_valid again.
- With TOK_LOADER_ACK_EN: good frame with tx_busy=1 held 10 cycles -> tx_wr pulses once with tx_data=4B on the first cycle tx_busy=0; bad frame -> tx_data=21.

Source files
------------

// File: rtl/tok_loader_if.sv
// rtl/tok_loader_if.sv - UART, program RAM, core control and ack bundle of the TOK boot loader
interface tok_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_error;
    logic              rx_rd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_din;
    logic              core_run;
    logic              busy;
    logic              load_err;
    logic              tx_wr;
    logic [7:0]        tx_data;
    logic              tx_busy;

    modport master (
        input  rx_valid, rx_data, rx_error, tx_busy,
        output rx_rd, ram_we, ram_waddr, ram_din, core_run, busy, load_err, tx_wr, tx_data
    );

    modport slave (
        output rx_valid, rx_data, rx_error, tx_busy,
        input  rx_rd, ram_we, ram_waddr, ram_din, core_run, busy, load_err, tx_wr, tx_data
    );
endinterface

// File: rtl/tok_loader.sv
// rtl/tok_loader.sv - UART frame boot loader for the TOK core; optional ack byte under TOK_LOADER_ACK_EN
module tok_loader #(
    parameter int         ADDR_W    = 8,
    parameter int         TIMEOUT   = 1000000,
    parameter logic [7:0] SYNC_CHAR = 8'h3A
) (
    input  logic         clk,
    input  logic         reset,
    tok_loader_if.master bus
);
    // Byte counter needs one extra bit so a full 2**ADDR_W image can be counted;
    // the length register must also hold 256 for LEN=0 even when ADDR_W is small.
    localparam int CW = ADDR_W + 1;
    localparam int LW = (CW > 9) ? CW : 9;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(2 ** ADDR_W);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN,
        S_DATA,
        S_SUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [LW-1:0]     len_q;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        sum_q;
    logic [TW-1:0]     to_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_waddr_q;
    logic [7:0]        ram_din_q;
    logic              core_run_q;
    logic              load_err_q;

    logic              in_frame;
    logic              accept;
    logic [LW-1:0]     len_d;
    logic [7:0]        sum_d;
    logic              go_err;
    logic              go_run;

    assign in_frame = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_SUM);
    assign bus.rx_rd = bus.rx_valid && (in_frame || (state_q == S_SYNC));
    // A byte read in the same cycle as a line break is consumed but discarded.
    assign accept = bus.rx_rd && !bus.rx_error;
    assign len_d = (bus.rx_data == 8'd0) ? LW'(256) : LW'(bus.rx_data);
    assign sum_d = sum_q + bus.rx_data;

    // Every path into ERR: break while hunting or framing, oversize length, bad
    // checksum, or the idle timer expiring without a byte arriving that cycle.
    assign go_err = ((state_q == S_SYNC) && bus.rx_error)
                 || (in_frame && (bus.rx_error
                                  || (accept && (((state_q == S_LEN) && (len_d > MAX_LEN))
                                              || ((state_q == S_SUM) && (sum_d != 8'd0))))
                                  || (!bus.rx_valid && (to_q == TO_LAST))));
    assign go_run = (state_q == S_SUM) && accept && (sum_d == 8'd0);

    // Loader FSM: frame parsing, RAM write strobes, core release and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_SYNC;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            to_q        <= '0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_din_q   <= '0;
            core_run_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            if (go_err) begin
                state_q    <= S_ERR;
                load_err_q <= 1'b1;
                to_q       <= '0;
            end else begin
                case (state_q)
                    S_SYNC: begin
                        if (accept && (bus.rx_data == SYNC_CHAR)) begin
                            state_q    <= S_LEN;
                            load_err_q <= 1'b0;
                        end
                        to_q <= '0;
                    end
                    S_LEN: begin
                        if (accept) begin
                            len_q   <= len_d;
                            sum_q   <= bus.rx_data;
                            cnt_q   <= '0;
                            to_q    <= '0;
                            state_q <= S_DATA;
                        end else begin
                            to_q <= to_q + TW'(1);
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            ram_we_q    <= 1'b1;
                            ram_waddr_q <= cnt_q[ADDR_W-1:0];
                            ram_din_q   <= bus.rx_data;
                            sum_q       <= sum_d;
                            cnt_q       <= cnt_q + CW'(1);
                            to_q        <= '0;
                            if (LW'(cnt_q) == (len_q - LW'(1))) begin
                                state_q <= S_SUM;
                            end
                        end else begin
                            to_q <= to_q + TW'(1);
                        end
                    end
                    S_SUM: begin
                        if (accept) begin
                            to_q       <= '0;
                            state_q    <= S_RUN;
                            core_run_q <= 1'b1;
                        end else begin
                            to_q <= to_q + TW'(1);
                        end
                    end
                    S_RUN: begin
                        if (bus.rx_error) begin
                            state_q    <= S_SYNC;
                            core_run_q <= 1'b0;
                        end
                    end
                    S_ERR: begin
                        state_q <= S_SYNC;
                    end
                    default: begin
                        state_q <= S_SYNC;
                    end
                endcase
            end
        end
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_waddr = ram_waddr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.core_run  = core_run_q;
    assign bus.load_err  = load_err_q;
    assign bus.busy      = in_frame;

`ifdef TOK_LOADER_ACK_EN
    logic       ack_pend_q;
    logic [7:0] tx_data_q;

    // Single-entry ack slot: a newer result overwrites an unsent one; the slot
    // drains on the first cycle the transmitter is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_pend_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else if (go_run) begin
            ack_pend_q <= 1'b1;
            tx_data_q  <= 8'h4B;
        end else if (go_err) begin
            ack_pend_q <= 1'b1;
            tx_data_q  <= 8'h21;
        end else if (ack_pend_q && !bus.tx_busy) begin
            ack_pend_q <= 1'b0;
        end
    end

    assign bus.tx_wr   = ack_pend_q && !bus.tx_busy;
    assign bus.tx_data = tx_data_q;
`else
    logic unused_tx_busy;
    assign unused_tx_busy = bus.tx_busy;
    assign bus.tx_wr      = 1'b0;
    assign bus.tx_data    = 8'h00;
`endif
endmodule

// File: tb/tb_tok_loader.sv
// tb/tb_tok_loader.sv - randomized self-checking bench for tok_loader against a frame-level model
module tb_tok_loader;
    localparam int AW = 8;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tok_loader_if #(.ADDR_W(AW)) bus ();

    tok_loader #(.ADDR_W(AW), .TIMEOUT(TO), .SYNC_CHAR(8'h3A)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Frame-level model: mode 0 hunting for sync, 1 collecting a frame,
    // 2 core running, 3 one-cycle error report.
    int         m_mode;
    logic [7:0] m_frame[$];
    int         m_idle;
    logic       e_we, e_run, e_err, e_pend;
    logic [7:0] e_addr, e_din, e_txd;
    logic [7:0] log_addr[$];
    logic [7:0] log_data[$];

    function automatic void m_init();
        m_mode = 0; m_frame.delete(); m_idle = 0;
        e_we = 0; e_run = 0; e_err = 0; e_pend = 0;
        e_addr = 0; e_din = 0; e_txd = 0;
    endfunction

    function automatic void m_abort();
        m_mode = 3; e_err = 1; e_pend = 1; e_txd = 8'h21;
    endfunction

    function automatic void m_step(input logic v, input logic [7:0] d, input logic e, input logic tb);
        int len, s;
        e_we = 0;
        if (e_pend && !tb) e_pend = 0;
        case (m_mode)
            3: m_mode = 0;
            2: if (e) begin m_mode = 0; e_run = 0; end
            0: begin
                if (e) m_abort();
                else if (v && d == 8'h3A) begin
                    m_mode = 1; m_frame.delete(); m_idle = 0; e_err = 0;
                end
            end
            default: begin
                if (e) m_abort();
                else if (v) begin
                    m_frame.push_back(d);
                    m_idle = 0;
                    len = (m_frame[0] == 0) ? 256 : int'(m_frame[0]);
                    if (m_frame.size() == 1) begin
                        if (len > (1 << AW)) m_abort();
                    end else if (m_frame.size() <= len + 1) begin
                        e_we = 1; e_addr = 8'(m_frame.size() - 2); e_din = d;
                    end else begin
                        s = 0;
                        foreach (m_frame[i]) s += int'(m_frame[i]);
                        if (s % 256 == 0) begin
                            m_mode = 2; e_run = 1; e_pend = 1; e_txd = 8'h4B;
                        end else m_abort();
                    end
                end else if (m_idle == TO - 1) m_abort();
                else m_idle++;
            end
        endcase
    endfunction

    // Compare every cycle at the falling edge; advance the model on the rising edge.
    initial begin
        m_init();
        forever begin
            @(negedge clk);
            if (reset) m_init();
            chk("rx_rd", bus.rx_rd, bus.rx_valid && (m_mode == 0 || m_mode == 1));
            chk("ram_we", bus.ram_we, e_we);
            chk("ram_waddr", bus.ram_waddr, e_addr);
            chk("ram_din", bus.ram_din, e_din);
            chk("core_run", bus.core_run, e_run);
            chk("load_err", bus.load_err, e_err);
            chk("busy", bus.busy, m_mode == 1);
`ifdef TOK_LOADER_ACK_EN
            chk("tx_wr", bus.tx_wr, e_pend && !bus.tx_busy);
            chk("tx_data", bus.tx_data, e_txd);
`else
            chk("tx_wr", bus.tx_wr, 0);
            chk("tx_data", bus.tx_data, 0);
`endif
            if (bus.ram_we) begin
                log_addr.push_back(bus.ram_waddr);
                log_data.push_back(bus.ram_din);
            end
            @(posedge clk);
            if (reset) m_init();
            else m_step(bus.rx_valid, bus.rx_data, bus.rx_error, bus.tx_busy);
        end
    end

    logic rnd_busy = 1'b0;

    task automatic cyc(input logic v, input logic [7:0] d, input logic e);
        bus.rx_valid = v; bus.rx_data = d; bus.rx_error = e;
        if (rnd_busy) bus.tx_busy = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        bus.rx_valid = 0; bus.rx_error = 0;
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) cyc(1'b1, q[i], 1'b0);
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete();
    endtask

    logic [7:0] q[$];
    int         n, len;
    logic [7:0] s, d;

    initial begin
        bus.rx_valid = 0; bus.rx_data = 0; bus.rx_error = 0; bus.tx_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_core_run", bus.core_run, 0);
        chk("rst_load_err", bus.load_err, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_waddr", bus.ram_waddr, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 0;
        cyc(0, 0, 0);

        // Good load
        clear_log();
`ifdef TOK_LOADER_ACK_EN
        bus.tx_busy = 1;
`endif
        q = '{8'h3A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_q(q);
        chk("good_run", bus.core_run, 1);
        chk("good_err", bus.load_err, 0);
        chk("good_nwr", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("good_a0", {log_addr[0], log_data[0]}, 16'h0011);
            chk("good_a1", {log_addr[1], log_data[1]}, 16'h0122);
            chk("good_a2", {log_addr[2], log_data[2]}, 16'h0233);
        end
`ifdef TOK_LOADER_ACK_EN
        repeat (9) begin
            chk("ack_held", bus.tx_wr, 0);
            cyc(0, 0, 0);
        end
        bus.tx_busy = 0;
        #1;
        chk("ack_wr", bus.tx_wr, 1);
        chk("ack_k", bus.tx_data, 8'h4B);
`endif
        cyc(0, 0, 0);

        // Break while running
        cyc(0, 0, 1);
        chk("brk_run", bus.core_run, 0);
        chk("brk_busy", bus.busy, 0);
        cyc(1, 8'h41, 0);

        // Bad checksum, then a good frame clears the error
        clear_log();
        q = '{8'h3A, 8'h02, 8'hAA, 8'hBB, 8'h00};
        send_q(q);
        chk("bad_err", bus.load_err, 1);
        chk("bad_run", bus.core_run, 0);
        chk("bad_nwr", log_addr.size(), 2);
        cyc(0, 0, 0);
`ifdef TOK_LOADER_ACK_EN
        chk("ack_bang", bus.tx_data, 8'h21);
`endif
        q = '{8'h3A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_q(q);
        chk("reload_err", bus.load_err, 0);
        chk("reload_run", bus.core_run, 1);
        cyc(0, 0, 1);

        // Garbage, then a 256-byte frame
        clear_log();
        q = '{8'h55, 8'h00, 8'h3A, 8'h00};
        send_q(q);
        for (int i = 0; i < 256; i++) cyc(1, 8'(i), 0);
        cyc(1, 8'h80, 0);
        chk("big_run", bus.core_run, 1);
        chk("big_nwr", log_addr.size(), 256);
        if (log_addr.size() == 256) begin
            chk("big_first", {log_addr[0], log_data[0]}, 16'h0000);
            chk("big_last", {log_addr[255], log_data[255]}, 16'hFFFF);
        end
        cyc(0, 0, 1);

        // Timeout after one data byte
        clear_log();
        q = '{8'h3A, 8'h04, 8'h01};
        send_q(q);
        repeat (TO - 1) cyc(0, 0, 0);
        chk("to_before", bus.load_err, 0);
        chk("to_busy", bus.busy, 1);
        cyc(0, 0, 0);
        chk("to_err", bus.load_err, 1);
        chk("to_nwr", log_addr.size(), 1);
        cyc(0, 0, 0);

        // Mid-frame reset
        q = '{8'h3A, 8'h05, 8'h01, 8'h02};
        send_q(q);
        clear_log();
        reset = 1;
        #1;
        chk("mr_we", bus.ram_we, 0);
        chk("mr_busy", bus.busy, 0);
        cyc(1, 8'h03, 0);
        reset = 0;
        repeat (3) cyc(0, 0, 0);
        chk("mr_nwr", log_addr.size(), 0);

        // Randomized frames with breaks, gaps, corrupt sums and timeouts
        rnd_busy = 1;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(0, 2);
            repeat (n) cyc(1, 8'($urandom_range(0, 255)), 0);
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            s = 8'(len);
            cyc(1, 8'h3A, 0);
            cyc(1, 8'(len), 0);
            for (int i = 0; i < ((len == 0) ? 256 : len); i++) begin
                d = 8'($urandom_range(0, 255));
                s = s + d;
                repeat ($urandom_range(0, 2)) cyc(0, 0, 0);
                cyc(1, d, ($urandom_range(0, 79) == 0));
                if (f % 10 == 3 && i == 0) repeat (TO + 2) cyc(0, 0, 0);
            end
            s = 8'h00 - s;
            if ($urandom_range(0, 3) == 0) s = s + 8'h01;
            cyc(1, s, 0);
            repeat ($urandom_range(1, 4)) cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 0);
            cyc(0, 0, 1);
            cyc(0, 0, 0);
        end
        rnd_busy = 0;
        bus.tx_busy = 0;
        repeat (3) cyc(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
